// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
//   Shared definitions for the CSR access controller:
//     - default address/data widths
//     - Zicsr funct3 op-codes
//     - well-known read-only counter CSR addresses
//     - controller state encoding
//     - csr_op_valid(): funct3 legality helper
// ---------------------------------------------------------------------------
package csr_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;

    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } csr_state_e;

    // funct3 000 and 100 are the only non-Zicsr encodings; both have op[1:0]==0.
    function automatic logic csr_op_valid(input logic [2:0] op);
        return op[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl_if
//   Bundles the requester handshake, the response strobe and the CSR
//   register-file read/write port of csr_access_ctrl.
//   Modports:
//     slave  - the controller (csr_access_ctrl)
//     master - its environment (execute stage + register file)
//   Optional: CSR_DEBUG_PORT_EN adds the dbg_* requester signals.
// ---------------------------------------------------------------------------
interface csr_access_ctrl_if
    import csr_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_W,
    parameter int DATA_W = CSR_DATA_W
) ();

    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        req_op_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_src_i;
    logic              req_srcZero_i;

    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_illegal_o;

    logic [ADDR_W-1:0] csrRaddr_o;
    logic [DATA_W-1:0] csrRData_i;
    logic [ADDR_W-1:0] csrWaddr_o;
    logic [DATA_W-1:0] csrWData_o;
    logic              csrWe_o;

`ifdef CSR_DEBUG_PORT_EN
    logic              dbg_req_valid_i;
    logic              dbg_req_ready_o;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_rsp_valid_o;
    logic [DATA_W-1:0] dbg_rdata_o;
`endif

    modport slave (
`ifdef CSR_DEBUG_PORT_EN
        input  dbg_req_valid_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_req_ready_o, dbg_rsp_valid_o, dbg_rdata_o,
`endif
        input  req_valid_i, req_op_i, req_addr_i, req_src_i, req_srcZero_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
        output csrRaddr_o, csrWaddr_o, csrWData_o, csrWe_o,
        input  csrRData_i
    );

    modport master (
`ifdef CSR_DEBUG_PORT_EN
        output dbg_req_valid_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_req_ready_o, dbg_rsp_valid_o, dbg_rdata_o,
`endif
        output req_valid_i, req_op_i, req_addr_i, req_src_i, req_srcZero_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
        input  csrRaddr_o, csrWaddr_o, csrWData_o, csrWe_o,
        output csrRData_i
    );

endinterface

// File: rtl/csr_alu.sv
// ---------------------------------------------------------------------------
// csr_alu
//   Combinational read-modify-write core for one Zicsr instruction.
//   Ports:
//     op_i        funct3 of the instruction
//     old_i       current CSR value
//     src_i       rs1 value or zero-extended zimm
//     src_zero_i  rs1 index / zimm field is zero
//     addr_i      CSR address
//     new_o       value to write back
//     we_o        write is enabled and legal
//     illegal_o   illegal-instruction condition
// ---------------------------------------------------------------------------
module csr_alu
    import csr_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_W,
    parameter int DATA_W = CSR_DATA_W
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] src_i,
    input  logic              src_zero_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] new_o,
    output logic              we_o,
    output logic              illegal_o
);

    logic wr_en;
    logic read_only;
    logic unused_addr_bits;

    // Register and immediate forms share op[1:0]; op[2] only picks the source upstream.
    always_comb begin
        new_o = old_i;
        case (op_i[1:0])
            CSR_OP_RW[1:0]: new_o = src_i;
            CSR_OP_RS[1:0]: new_o = old_i | src_i;
            CSR_OP_RC[1:0]: new_o = old_i & ~src_i;
            default:        new_o = old_i;
        endcase
    end

    // Set/clear with a zero source is a pure read, so it may target read-only space.
    assign wr_en     = (op_i[1:0] == CSR_OP_RW[1:0]) || !src_zero_i;
    assign read_only = (addr_i[ADDR_W-1 -: 2] == CSR_CYCLE[11:10]);
    assign illegal_o = !csr_op_valid(op_i) || (wr_en && read_only);
    assign we_o      = wr_en && !illegal_o;

    assign unused_addr_bits = ^addr_i[ADDR_W-3:0];

endmodule

// File: rtl/csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl
//   Sequences Zicsr instructions against a single-read/single-write CSR
//   register file: read old value, write the modified value, respond.
//   Ports:
//     clk_i     clock
//     reset_ni  asynchronous active-low reset
//     bus       csr_access_ctrl_if.slave (request, response, reg-file port)
//   Optional feature macro: CSR_DEBUG_PORT_EN adds a round-robin arbitrated
//   debug requester (plain read / plain write).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; arbitration happens here
//   READ    | csrRaddr_o = latched address, old value captured at cycle end
//   EXEC    | write strobe issued when enabled and legal
//   RESP    | one-cycle response to the granted requester
// ---------------------------------------------------------------------------
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_W,
    parameter int DATA_W = CSR_DATA_W
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    csr_access_ctrl_if.slave bus
);

    csr_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic              src_zero_q, src_zero_d;
    logic [DATA_W-1:0] old_q, old_d;

    logic              st_idle, st_exec, st_resp;
    logic              grant_pipe, pipe_accept;
    logic [DATA_W-1:0] alu_new;
    logic              alu_we, alu_illegal;

`ifdef CSR_DEBUG_PORT_EN
    localparam logic GNT_PIPE = 1'b0;
    localparam logic GNT_DBG  = 1'b1;

    logic last_grant_q, last_grant_d;
    logic dbg_side_q, dbg_side_d;
    logic grant_dbg, dbg_accept;
`endif

    assign st_idle = (state_q == ST_IDLE);
    assign st_exec = (state_q == ST_EXEC);
    assign st_resp = (state_q == ST_RESP);

`ifdef CSR_DEBUG_PORT_EN
    // Debug wins when alone, or on a tie when the pipeline had the last grant.
    assign grant_dbg  = bus.dbg_req_valid_i && (!bus.req_valid_i || (last_grant_q == GNT_PIPE));
    assign grant_pipe = !grant_dbg;
    assign dbg_accept = st_idle && grant_dbg;
    assign bus.dbg_req_ready_o = st_idle && grant_dbg;
`else
    assign grant_pipe = 1'b1;
`endif

    assign bus.req_ready_o = st_idle && grant_pipe;
    assign pipe_accept     = bus.req_valid_i && bus.req_ready_o;

    csr_alu #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i       (op_q),
        .old_i      (old_q),
        .src_i      (src_q),
        .src_zero_i (src_zero_q),
        .addr_i     (addr_q),
        .new_o      (alu_new),
        .we_o       (alu_we),
        .illegal_o  (alu_illegal)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        src_d      = src_q;
        src_zero_d = src_zero_q;
        old_d      = old_q;
`ifdef CSR_DEBUG_PORT_EN
        last_grant_d = last_grant_q;
        dbg_side_d   = dbg_side_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pipe_accept) begin
                    op_d       = bus.req_op_i;
                    addr_d     = bus.req_addr_i;
                    src_d      = bus.req_src_i;
                    src_zero_d = bus.req_srcZero_i;
                    state_d    = ST_READ;
`ifdef CSR_DEBUG_PORT_EN
                    last_grant_d = GNT_PIPE;
                    dbg_side_d   = 1'b0;
`endif
                end
`ifdef CSR_DEBUG_PORT_EN
                else if (dbg_accept) begin
                    // Debug write behaves as CSRRW; debug read as a zero-source CSRRS.
                    op_d         = bus.dbg_we_i ? CSR_OP_RW : CSR_OP_RS;
                    addr_d       = bus.dbg_addr_i;
                    src_d        = bus.dbg_wdata_i;
                    src_zero_d   = !bus.dbg_we_i;
                    last_grant_d = GNT_DBG;
                    dbg_side_d   = 1'b1;
                    state_d      = ST_READ;
                end
`endif
            end
            ST_READ: begin
                old_d   = bus.csrRData_i;
                state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            old_q      <= '0;
`ifdef CSR_DEBUG_PORT_EN
            last_grant_q <= GNT_DBG;
            dbg_side_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            src_zero_q <= src_zero_d;
            old_q      <= old_d;
`ifdef CSR_DEBUG_PORT_EN
            last_grant_q <= last_grant_d;
            dbg_side_q   <= dbg_side_d;
`endif
        end
    end

    assign bus.csrRaddr_o = addr_q;
    assign bus.csrWaddr_o = addr_q;
    assign bus.csrWData_o = st_exec ? alu_new : '0;
    assign bus.csrWe_o    = st_exec && alu_we;

`ifdef CSR_DEBUG_PORT_EN
    // Illegal debug writes are dropped by the ALU but still return the old value.
    assign bus.rsp_valid_o     = st_resp && !dbg_side_q;
    assign bus.rsp_illegal_o   = st_resp && !dbg_side_q && alu_illegal;
    assign bus.rsp_rdata_o     = (st_resp && !dbg_side_q && !alu_illegal) ? old_q : '0;
    assign bus.dbg_rsp_valid_o = st_resp && dbg_side_q;
    assign bus.dbg_rdata_o     = (st_resp && dbg_side_q) ? old_q : '0;
`else
    assign bus.rsp_valid_o   = st_resp;
    assign bus.rsp_illegal_o = st_resp && alu_illegal;
    assign bus.rsp_rdata_o   = (st_resp && !alu_illegal) ? old_q : '0;
`endif

endmodule

// File: tb/tb_csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_access_ctrl
//   Self-checking bench for csr_access_ctrl: directed cases plus randomized
//   requests compared against a behavioural model of the Zicsr rules.
// ---------------------------------------------------------------------------
module tb_csr_access_ctrl;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csr_access_ctrl_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    csr_access_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    logic [31:0] rf      [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [11:0] pool    [0:10];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int rsp_cnt = 0;
    int wr_cnt  = 0;
    int acc_q[$];

    // Register file environment: combinational read, clocked write.
    assign bus.csrRData_i = rf[bus.csrRaddr_o];

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (bus.csrWe_o) rf[bus.csrWaddr_o] <= bus.csrWData_o;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid_i && bus.req_ready_o) acc_q.push_back(cyc);
        if (bus.rsp_valid_o) rsp_cnt++;
        if (bus.csrWe_o) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = v;
    endtask

    // Issue one request from a negedge with the DUT idle; check each phase.
    task automatic run_req(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic sz);
        logic [31:0] old, nv;
        logic        wen, ill, exp_we;
        int          waited;

        old = ref_mem[addr];
        wen = (op == CSR_OP_RW) || (op == CSR_OP_RWI) || !sz;
        ill = (op == 3'b000) || (op == 3'b100) || (wen && (addr >= 12'hC00));
        case (op)
            CSR_OP_RW, CSR_OP_RWI: nv = src;
            CSR_OP_RS, CSR_OP_RSI: nv = old | src;
            CSR_OP_RC, CSR_OP_RCI: nv = old & ~src;
            default:               nv = old;
        endcase
        exp_we = wen && !ill;

        bus.req_valid_i   = 1'b1;
        bus.req_op_i      = op;
        bus.req_addr_i    = addr;
        bus.req_src_i     = src;
        bus.req_srcZero_i = sz;
        waited = 0;
        while (bus.req_ready_o !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", bus.req_ready_o, 1'b1);

        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("read_ready", bus.req_ready_o, 1'b0);
        chk("read_raddr", bus.csrRaddr_o, addr);
        chk("read_we", bus.csrWe_o, 1'b0);

        @(negedge clk);
        chk("exec_we", bus.csrWe_o, exp_we);
        chk("exec_rsp", bus.rsp_valid_o, 1'b0);
        if (exp_we) begin
            chk("exec_wdata", bus.csrWData_o, nv);
            chk("exec_waddr", bus.csrWaddr_o, addr);
        end

        @(negedge clk);
        chk("rsp_valid", bus.rsp_valid_o, 1'b1);
        chk("rsp_illegal", bus.rsp_illegal_o, ill);
        chk("rsp_rdata", bus.rsp_rdata_o, ill ? 32'h0 : old);
        chk("rsp_we", bus.csrWe_o, 1'b0);

        if (exp_we) ref_mem[addr] = nv;

        @(negedge clk);
        chk("post_valid", bus.rsp_valid_o, 1'b0);
        chk("post_ready", bus.req_ready_o, 1'b1);
        chk("rf_state", rf[addr], ref_mem[addr]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [11:0] raddr;
        logic [31:0] rsrc;
        logic        rsz;
        int          wr0, rs0, gap;

        rst_n = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_addr_i = '0;
        bus.req_src_i = '0; bus.req_srcZero_i = 1'b0;
`ifdef CSR_DEBUG_PORT_EN
        bus.dbg_req_valid_i = 1'b0; bus.dbg_we_i = 1'b0;
        bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
`endif
        pool = '{12'h340, 12'h341, 12'h300, 12'h305, 12'h7C0, 12'hB00, 12'hF11,
                 CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH};

        repeat (2) @(negedge clk);
        chk("rst_ready", bus.req_ready_o, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("rst_illegal", bus.rsp_illegal_o, 1'b0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst_we", bus.csrWe_o, 1'b0);
        chk("rst_raddr", bus.csrRaddr_o, 12'h0);
        chk("rst_waddr", bus.csrWaddr_o, 12'h0);
        chk("rst_wdata", bus.csrWData_o, 32'h0);

        for (int i = 0; i < 11; i++) preload(pool[i], $urandom());
        rst_n = 1'b1;
        @(negedge clk);

        // CSRRW
        preload(12'h340, 32'h1234_5678);
        run_req(CSR_OP_RW, 12'h340, 32'hDEAD_BEEF, 1'b0);

        // CSRRS / CSRRC / CSRRS with zero source
        preload(12'h341, 32'h0000_00F0);
        run_req(CSR_OP_RS, 12'h341, 32'h0000_0F0F, 1'b0);
        preload(12'h341, 32'h0000_00F0);
        run_req(CSR_OP_RC, 12'h341, 32'h0000_0F0F, 1'b0);
        preload(12'h341, 32'h0000_00F0);
        run_req(CSR_OP_RS, 12'h341, 32'h0, 1'b1);

        // Read-only space and illegal funct3
        preload(CSR_CYCLE, 32'h55);
        run_req(CSR_OP_RS, CSR_CYCLE, 32'h0, 1'b1);
        run_req(CSR_OP_RW, CSR_INSTRET, 32'h0000_0001, 1'b0);
        run_req(CSR_OP_RCI, CSR_CYCLEH, 32'h0000_0004, 1'b0);
        run_req(3'b100, 12'h340, 32'h0000_0003, 1'b0);
        run_req(3'b000, 12'h300, 32'h0, 1'b1);

        // Back-to-back: valid held high across two requests
        acc_q.delete();
        rs0 = rsp_cnt;
        bus.req_valid_i = 1'b1; bus.req_op_i = CSR_OP_RW; bus.req_addr_i = 12'h300;
        bus.req_src_i = 32'hAAAA_0001; bus.req_srcZero_i = 1'b0;
        @(negedge clk);
        chk("b2b_first_accept", acc_q.size(), 1);
        ref_mem[12'h300] = 32'hAAAA_0001;
        bus.req_addr_i = 12'h305; bus.req_src_i = 32'hBBBB_0002;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_ready_low", bus.req_ready_o, 1'b0);
            @(negedge clk);
        end
        chk("b2b_ready_back", bus.req_ready_o, 1'b1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        gap = (acc_q.size() >= 2) ? (acc_q[1] - acc_q[0]) : -1;
        chk("b2b_gap", gap, 4);
        ref_mem[12'h305] = 32'hBBBB_0002;
        repeat (4) @(negedge clk);
        chk("b2b_rsp_count", rsp_cnt - rs0, 2);
        chk("b2b_rf_a", rf[12'h300], ref_mem[12'h300]);
        chk("b2b_rf_b", rf[12'h305], ref_mem[12'h305]);

        // Reset asserted during EXEC aborts the request
        preload(12'h340, 32'hCAFE_0001);
        wr0 = wr_cnt; rs0 = rsp_cnt;
        bus.req_valid_i = 1'b1; bus.req_op_i = CSR_OP_RW; bus.req_addr_i = 12'h340;
        bus.req_src_i = 32'h1111_2222; bus.req_srcZero_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_pre_we", bus.csrWe_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we", bus.csrWe_o, 1'b0);
        chk("abort_rsp", bus.rsp_valid_o, 1'b0);
        chk("abort_ready", bus.req_ready_o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_rsp_late", bus.rsp_valid_o, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_wr_count", wr_cnt - wr0, 0);
        chk("abort_rsp_count", rsp_cnt - rs0, 0);
        chk("abort_rf", rf[12'h340], ref_mem[12'h340]);

`ifdef CSR_DEBUG_PORT_EN
        preload(12'h340, 32'h0000_1234);
        bus.dbg_req_valid_i = 1'b1; bus.dbg_we_i = 1'b1;
        bus.dbg_addr_i = 12'h340; bus.dbg_wdata_i = 32'hA5;
        bus.req_valid_i = 1'b1; bus.req_op_i = CSR_OP_RS; bus.req_addr_i = 12'h341;
        bus.req_src_i = 32'h0; bus.req_srcZero_i = 1'b1;
        chk("arb_pipe_ready", bus.req_ready_o, 1'b1);
        chk("arb_dbg_ready", bus.dbg_req_ready_o, 1'b0);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arb_pipe_rsp", bus.rsp_valid_o, 1'b1);
        chk("arb_pipe_rdata", bus.rsp_rdata_o, ref_mem[12'h341]);
        chk("arb_dbg_rsp_quiet", bus.dbg_rsp_valid_o, 1'b0);
        @(negedge clk);
        chk("arb_dbg_ready2", bus.dbg_req_ready_o, 1'b1);
        chk("arb_pipe_ready2", bus.req_ready_o, 1'b0);
        @(negedge clk);
        bus.dbg_req_valid_i = 1'b0;
        @(negedge clk);
        chk("dbg_we", bus.csrWe_o, 1'b1);
        chk("dbg_wdata", bus.csrWData_o, 32'hA5);
        @(negedge clk);
        chk("dbg_rsp", bus.dbg_rsp_valid_o, 1'b1);
        chk("dbg_rdata", bus.dbg_rdata_o, ref_mem[12'h340]);
        chk("dbg_pipe_quiet", bus.rsp_valid_o, 1'b0);
        ref_mem[12'h340] = 32'hA5;
        @(negedge clk);
        run_req(CSR_OP_RS, 12'h340, 32'h0, 1'b1);
`endif

        // Randomized requests against the model
        for (int i = 0; i < 150; i++) begin
            rop   = 3'($urandom_range(0, 7));
            raddr = pool[$urandom_range(0, 10)];
            rsz   = ($urandom_range(0, 3) == 0);
            rsrc  = rsz ? 32'h0 : $urandom();
            run_req(rop, raddr, rsrc, rsz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
